sdram_burst_arbiter: RTL and testbench
======================================

# sdram_burst_arbiter

Two-client arbiter between the io_sdram burst-read port and its DMA clients (client 0: dot-product accelerator, client 1: second streaming engine). Each client issues single-cycle burst read requests. The arbiter latches them, grants the single SDRAM burst port round-robin, and routes returned data, valid and done back to the granted client only. It also completes zero-length requests locally and aborts bursts that never finish.

## Interface
- TIMEOUT, 65535: cycles in BUSY without mem_burst_data_done before a forced abort.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cN_burst_rd  in  1  client N request pulse (N = 0, 1); one cycle high
- cN_burst_addr  in  25  client N half-word address, sampled with request
- cN_burst_len  in  11  client N length in half-words, sampled with request
- cN_burst_32bit  in  1  client N width flag, sampled with request
- cN_burst_data  out  32  mem_burst_data, fanned out unmodified
- cN_burst_data_valid  out  1  data strobe for client N
- cN_burst_data_done  out  1  completion pulse for client N
- mem_burst_rd  out  1  registered request pulse to io_sdram
- mem_burst_addr  out  25  registered address to io_sdram
- mem_burst_len  out  11  registered length to io_sdram
- mem_burst_32bit  out  1  registered width flag to io_sdram
- mem_burst_data  in  32  data from io_sdram
- mem_burst_data_valid  in  1  data strobe from io_sdram
- mem_burst_data_done  in  1  completion from io_sdram
- err_overrun  out  1  sticky: a request arrived while the same client already had one pending
- err_timeout  out  1  sticky: a burst was aborted by timeout

## Operation
- Per-client pending slot: pend_N, addr, len, 32bit flag.
  - cN_burst_rd=1 with pend_N=0 captures the fields and sets pend_N.
  - cN_burst_rd=1 with pend_N=1 is dropped; err_overrun is set and the slot is not overwritten.
- States: IDLE, BUSY, LOCAL_DONE.
- IDLE:
  - If both slots are pending, choose the client whose index equals the priority bit (prio). Otherwise choose the single pending client.
  - If the chosen len≠0: mem_burst_rd<=1 with that slot's fields, grant<=N, clear pend_N, timer<=0, go to BUSY.
  - If the chosen len=0: grant<=N, clear pend_N, go to LOCAL_DONE. Nothing is issued to io_sdram.
- BUSY:
  - cN_burst_data_valid = mem_burst_data_valid & (grant==N) & BUSY (combinational).
  - cN_burst_data_done = mem_burst_data_done & (grant==N) & BUSY (combinational).
  - On mem_burst_data_done: prio<=~grant, go to IDLE.
  - timer increments every BUSY cycle. When timer==TIMEOUT-1 with no done: pulse cN_burst_data_done (registered) for the granted client, set err_timeout, prio<=~grant, go to IDLE.
- LOCAL_DONE: pulse cN_burst_data_done for the granted client for one cycle; prio<=~grant; go to IDLE.
- In IDLE or LOCAL_DONE, mem valid/done are ignored. Stray strobes never reach a client.
- A request arriving while a burst is BUSY for the other client is latched and served after done.
- err_* bits clear only on reset.

## Timing
- Reset values:
  - mem_burst_rd=0, mem_burst_addr=0, mem_burst_len=0, mem_burst_32bit=0.
  - All cN_* valid/done=0; cN_burst_data follows mem_burst_data.
  - pend=0, prio=0 (client 0 first), state IDLE, timer=0, err_*=0.
- Request latency:
  - cN_burst_rd high in cycle k → pend_N=1 in cycle k+1.
  - mem_burst_rd high for exactly one cycle, k+2, if the arbiter is IDLE.
- Back-to-back:
  - mem_burst_data_done in cycle d → IDLE in d+1 → next mem_burst_rd in d+2 at the earliest.
- A client request and a pend clear for the same client in the same cycle: capture wins, so pend stays 1 with the new fields.
- Data-path routing is combinational and adds 0 cycles of latency to valid, data and done.
- Zero-length request: client done pulse 3 cycles after cN_burst_rd.
- Reset mid-burst: everything returns to reset values. Later io_sdram strobes from the abandoned burst are ignored because the state is IDLE.

## Test plan
- Single request: c0 requests addr 0x000100, len 8 → mem_burst_rd one cycle at k+2 with addr 0x000100, len 8. Then 4 mem valids route to c0 only, c1 stays silent, and c0 done follows mem done.
- Simultaneous requests at reset, c0 and c1 in the same cycle → c0 served first, then c1 issued exactly 2 cycles after c0's done. A second simultaneous pair → c1 served first.
- Overrun: c1 requests twice while c0 holds the grant → only the first c1 fields are issued, and err_overrun=1.
- Zero length: c0 requests len 0 → no mem_burst_rd, and c0 done pulses in cycle k+3.
- Timeout (TIMEOUT=16): io_sdram never sends done → c0 done pulses after 16 BUSY cycles, err_timeout=1, and a pending c1 is served next.
- Reset mid-burst: reset_n low during a c0 burst, then io_sdram emits 3 valids and done → no client strobes, and all outputs hold their reset values.

Source files
------------

// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter
//   Shares the single io_sdram burst-read port between two DMA clients.
//   Each client's single-cycle request is latched into a pending slot.
//   Pending slots are granted round-robin. Returned data/valid/done are
//   routed combinationally to the granted client only. Zero-length
//   requests are completed locally. Bursts that never finish are aborted
//   after TIMEOUT cycles in BUSY.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   cN_burst_rd/addr/len/32bit   client N request pulse and fields (N = 0, 1)
//   cN_burst_data/_valid/_done   client N return path
//   mem_burst_rd/addr/len/32bit  registered request to io_sdram
//   mem_burst_data/_valid/_done  return path from io_sdram
//   err_overrun, err_timeout     sticky error flags, cleared only by reset

module sdram_burst_arbiter #(
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        c0_burst_rd,
    input  logic [24:0] c0_burst_addr,
    input  logic [10:0] c0_burst_len,
    input  logic        c0_burst_32bit,
    output logic [31:0] c0_burst_data,
    output logic        c0_burst_data_valid,
    output logic        c0_burst_data_done,

    input  logic        c1_burst_rd,
    input  logic [24:0] c1_burst_addr,
    input  logic [10:0] c1_burst_len,
    input  logic        c1_burst_32bit,
    output logic [31:0] c1_burst_data,
    output logic        c1_burst_data_valid,
    output logic        c1_burst_data_done,

    output logic        mem_burst_rd,
    output logic [24:0] mem_burst_addr,
    output logic [10:0] mem_burst_len,
    output logic        mem_burst_32bit,
    input  logic [31:0] mem_burst_data,
    input  logic        mem_burst_data_valid,
    input  logic        mem_burst_data_done,

    output logic        err_overrun,
    output logic        err_timeout
);

    // Timer only ever has to hold TIMEOUT-1.
    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_LOCAL_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         pend_q, pend_d;
    logic [1:0][24:0]   slot_addr_q, slot_addr_d;
    logic [1:0][10:0]   slot_len_q, slot_len_d;
    logic [1:0]         slot_w_q, slot_w_d;
    logic               grant_q, grant_d;
    logic               prio_q, prio_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               mem_rd_q, mem_rd_d;
    logic [24:0]        mem_addr_q, mem_addr_d;
    logic [10:0]        mem_len_q, mem_len_d;
    logic               mem_w_q, mem_w_d;
    logic [1:0]         ldone_q, ldone_d;
    logic               err_ov_q, err_ov_d;
    logic               err_to_q, err_to_d;

    logic [1:0]         req;
    logic [1:0][24:0]   req_addr;
    logic [1:0][10:0]   req_len;
    logic [1:0]         req_w;
    logic               pick;
    logic               busy;

    always_comb begin
        req      = {c1_burst_rd, c0_burst_rd};
        req_addr = {c1_burst_addr, c0_burst_addr};
        req_len  = {c1_burst_len, c0_burst_len};
        req_w    = {c1_burst_32bit, c0_burst_32bit};
        // Both pending: prio names the winner; otherwise the lone pending one.
        pick     = (&pend_q) ? prio_q : pend_q[1];
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        slot_addr_d = slot_addr_q;
        slot_len_d  = slot_len_q;
        slot_w_d    = slot_w_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        timer_d     = timer_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_len_d   = mem_len_q;
        mem_w_d     = mem_w_q;
        ldone_d     = '0;
        err_ov_d    = err_ov_q;
        err_to_d    = err_to_q;

        unique case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    grant_d      = pick;
                    pend_d[pick] = 1'b0;
                    if (slot_len_q[pick] != '0) begin
                        mem_rd_d   = 1'b1;
                        mem_addr_d = slot_addr_q[pick];
                        mem_len_d  = slot_len_q[pick];
                        mem_w_d    = slot_w_q[pick];
                        timer_d    = '0;
                        state_d    = S_BUSY;
                    end else begin
                        state_d    = S_LOCAL_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (mem_burst_data_done) begin
                    prio_d  = ~grant_q;
                    state_d = S_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    ldone_d[grant_q] = 1'b1;
                    err_to_d         = 1'b1;
                    prio_d           = ~grant_q;
                    state_d          = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_LOCAL_DONE: begin
                ldone_d[grant_q] = 1'b1;
                prio_d           = ~grant_q;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Capture is evaluated after the grant's clear, so a request landing
        // in the same cycle its slot is consumed refills the slot.
        for (int unsigned n = 0; n < 2; n++) begin
            if (req[n]) begin
                if (pend_d[n]) begin
                    err_ov_d = 1'b1;
                end else begin
                    pend_d[n]      = 1'b1;
                    slot_addr_d[n] = req_addr[n];
                    slot_len_d[n]  = req_len[n];
                    slot_w_d[n]    = req_w[n];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            slot_addr_q <= '0;
            slot_len_q  <= '0;
            slot_w_q    <= '0;
            grant_q     <= 1'b0;
            prio_q      <= 1'b0;
            timer_q     <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_len_q   <= '0;
            mem_w_q     <= 1'b0;
            ldone_q     <= '0;
            err_ov_q    <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            slot_addr_q <= slot_addr_d;
            slot_len_q  <= slot_len_d;
            slot_w_q    <= slot_w_d;
            grant_q     <= grant_d;
            prio_q      <= prio_d;
            timer_q     <= timer_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_len_q   <= mem_len_d;
            mem_w_q     <= mem_w_d;
            ldone_q     <= ldone_d;
            err_ov_q    <= err_ov_d;
            err_to_q    <= err_to_d;
        end
    end

    // Strobes from io_sdram only reach a client while its burst is BUSY.
    assign busy = (state_q == S_BUSY);

    assign c0_burst_data       = mem_burst_data;
    assign c1_burst_data       = mem_burst_data;
    assign c0_burst_data_valid = mem_burst_data_valid & busy & ~grant_q;
    assign c1_burst_data_valid = mem_burst_data_valid & busy &  grant_q;
    assign c0_burst_data_done  = (mem_burst_data_done & busy & ~grant_q) | ldone_q[0];
    assign c1_burst_data_done  = (mem_burst_data_done & busy &  grant_q) | ldone_q[1];

    assign mem_burst_rd    = mem_rd_q;
    assign mem_burst_addr  = mem_addr_q;
    assign mem_burst_len   = mem_len_q;
    assign mem_burst_32bit = mem_w_q;
    assign err_overrun     = err_ov_q;
    assign err_timeout     = err_to_q;

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// tb_sdram_burst_arbiter
//   Directed stimulus for sdram_burst_arbiter (TIMEOUT overridden to 16).
//   A time-scheduled reference model (issue cycle, local-done cycle, free
//   cycle) predicts every output each cycle; directed steps add literal
//   latency/field expectations on top.

module tb_sdram_burst_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        c0_burst_rd = 1'b0, c1_burst_rd = 1'b0;
    logic [24:0] c0_burst_addr = '0, c1_burst_addr = '0;
    logic [10:0] c0_burst_len = '0, c1_burst_len = '0;
    logic        c0_burst_32bit = 1'b0, c1_burst_32bit = 1'b0;
    logic [31:0] c0_burst_data, c1_burst_data;
    logic        c0_burst_data_valid, c1_burst_data_valid;
    logic        c0_burst_data_done, c1_burst_data_done;
    logic        mem_burst_rd;
    logic [24:0] mem_burst_addr;
    logic [10:0] mem_burst_len;
    logic        mem_burst_32bit;
    logic [31:0] mem_burst_data = '0;
    logic        mem_burst_data_valid = 1'b0;
    logic        mem_burst_data_done = 1'b0;
    logic        err_overrun, err_timeout;

    sdram_burst_arbiter #(.TIMEOUT(TO)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .c0_burst_rd         (c0_burst_rd),
        .c0_burst_addr       (c0_burst_addr),
        .c0_burst_len        (c0_burst_len),
        .c0_burst_32bit      (c0_burst_32bit),
        .c0_burst_data       (c0_burst_data),
        .c0_burst_data_valid (c0_burst_data_valid),
        .c0_burst_data_done  (c0_burst_data_done),
        .c1_burst_rd         (c1_burst_rd),
        .c1_burst_addr       (c1_burst_addr),
        .c1_burst_len        (c1_burst_len),
        .c1_burst_32bit      (c1_burst_32bit),
        .c1_burst_data       (c1_burst_data),
        .c1_burst_data_valid (c1_burst_data_valid),
        .c1_burst_data_done  (c1_burst_data_done),
        .mem_burst_rd        (mem_burst_rd),
        .mem_burst_addr      (mem_burst_addr),
        .mem_burst_len       (mem_burst_len),
        .mem_burst_32bit     (mem_burst_32bit),
        .mem_burst_data      (mem_burst_data),
        .mem_burst_data_valid(mem_burst_data_valid),
        .mem_burst_data_done (mem_burst_data_done),
        .err_overrun         (err_overrun),
        .err_timeout         (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int mcyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, mcyc);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_pend [2];
    logic [24:0] m_addr [2];
    logic [10:0] m_len  [2];
    logic        m_w    [2];
    bit          m_prio;
    int          m_owner;     // client whose burst io_sdram is serving, -1 none
    int          m_issue_cyc; // cycle mem_burst_rd is visible
    int          m_free_cyc;  // first cycle a new grant may be decided
    int          m_ld_cyc;    // cycle of a locally generated done pulse
    int          m_ld_cli;
    logic [24:0] m_maddr;
    logic [10:0] m_mlen;
    logic        m_mw;
    bit          m_eov, m_eto;

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0; m_addr[i] = '0; m_len[i] = '0; m_w[i] = 1'b0;
        end
        m_prio = 0; m_owner = -1; m_issue_cyc = -10; m_free_cyc = 0;
        m_ld_cyc = -10; m_ld_cli = 0;
        m_maddr = '0; m_mlen = '0; m_mw = 1'b0; m_eov = 0; m_eto = 0;
    endtask

    // observed-event monitors for the literal checks
    int          rd_cnt = 0, last_rd_cyc = -1;
    logic [24:0] last_rd_addr = '0;
    logic [10:0] last_rd_len = '0;
    int          v0_cnt = 0, v1_cnt = 0, d0_cnt = 0, d1_cnt = 0;
    int          last_d0 = -1, last_d1 = -1;

    initial begin : cmp
        int  n;
        bit  serving;
        bit  ev0, ev1, ed0, ed1;
        bit  rq [2];
        logic [24:0] ra [2];
        logic [10:0] rl [2];
        logic        rw [2];
        m_reset();
        forever begin
            @(negedge clk);
            #2;
            if (!reset_n) m_reset();
            serving = (m_owner >= 0);
            ev0 = serving && m_owner == 0 && mem_burst_data_valid;
            ev1 = serving && m_owner == 1 && mem_burst_data_valid;
            ed0 = (serving && m_owner == 0 && mem_burst_data_done) || (mcyc == m_ld_cyc && m_ld_cli == 0);
            ed1 = (serving && m_owner == 1 && mem_burst_data_done) || (mcyc == m_ld_cyc && m_ld_cli == 1);

            chk("mem_rd",    mem_burst_rd, mcyc == m_issue_cyc);
            chk("mem_addr",  mem_burst_addr, m_maddr);
            chk("mem_len",   mem_burst_len, m_mlen);
            chk("mem_32bit", mem_burst_32bit, m_mw);
            chk("c0_valid",  c0_burst_data_valid, ev0);
            chk("c1_valid",  c1_burst_data_valid, ev1);
            chk("c0_done",   c0_burst_data_done, ed0);
            chk("c1_done",   c1_burst_data_done, ed1);
            chk("c0_data",   c0_burst_data, mem_burst_data);
            chk("c1_data",   c1_burst_data, mem_burst_data);
            chk("err_overrun", err_overrun, m_eov);
            chk("err_timeout", err_timeout, m_eto);

            if (mem_burst_rd) begin
                rd_cnt++; last_rd_cyc = mcyc;
                last_rd_addr = mem_burst_addr; last_rd_len = mem_burst_len;
            end
            if (c0_burst_data_valid) v0_cnt++;
            if (c1_burst_data_valid) v1_cnt++;
            if (c0_burst_data_done) begin d0_cnt++; last_d0 = mcyc; end
            if (c1_burst_data_done) begin d1_cnt++; last_d1 = mcyc; end

            if (reset_n) begin
                if (serving) begin
                    if (mem_burst_data_done) begin
                        m_prio = (m_owner == 0); m_owner = -1; m_free_cyc = mcyc + 1;
                    end else if (mcyc - m_issue_cyc + 1 == TO) begin
                        m_ld_cyc = mcyc + 1; m_ld_cli = m_owner; m_eto = 1;
                        m_prio = (m_owner == 0); m_owner = -1; m_free_cyc = mcyc + 1;
                    end
                end else if (mcyc >= m_free_cyc && (m_pend[0] || m_pend[1])) begin
                    n = (m_pend[0] && m_pend[1]) ? (m_prio ? 1 : 0) : (m_pend[1] ? 1 : 0);
                    m_pend[n] = 0;
                    if (m_len[n] != 0) begin
                        m_owner = n; m_issue_cyc = mcyc + 1;
                        m_maddr = m_addr[n]; m_mlen = m_len[n]; m_mw = m_w[n];
                    end else begin
                        m_ld_cyc = mcyc + 2; m_ld_cli = n;
                        m_free_cyc = mcyc + 2; m_prio = (n == 0);
                    end
                end
                rq[0] = c0_burst_rd; ra[0] = c0_burst_addr; rl[0] = c0_burst_len; rw[0] = c0_burst_32bit;
                rq[1] = c1_burst_rd; ra[1] = c1_burst_addr; rl[1] = c1_burst_len; rw[1] = c1_burst_32bit;
                for (int i = 0; i < 2; i++) begin
                    if (rq[i]) begin
                        if (m_pend[i]) m_eov = 1;
                        else begin
                            m_pend[i] = 1; m_addr[i] = ra[i]; m_len[i] = rl[i]; m_w[i] = rw[i];
                        end
                    end
                end
            end
            mcyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_req(input int c, input logic [24:0] a, input logic [10:0] l, input logic w);
        if (c == 0) begin
            c0_burst_rd = 1'b1; c0_burst_addr = a; c0_burst_len = l; c0_burst_32bit = w;
        end else begin
            c1_burst_rd = 1'b1; c1_burst_addr = a; c1_burst_len = l; c1_burst_32bit = w;
        end
    endtask

    task automatic clr_req();
        c0_burst_rd = 1'b0;
        c1_burst_rd = 1'b0;
    endtask

    // nv valid cycles, then one done cycle; returns one cycle after done
    task automatic mem_xfer(input int nv);
        for (int i = 0; i < nv; i++) begin
            mem_burst_data_valid = 1'b1; mem_burst_data = $urandom; tick(1);
        end
        mem_burst_data_valid = 1'b0; mem_burst_data_done = 1'b1; tick(1);
        mem_burst_data_done = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k, d, b_rd, b_v0, b_v1, b_d0, b_d1;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        chk("reset_addr", mem_burst_addr, 25'h0);
        chk("reset_errs", {err_overrun, err_timeout}, 2'b00);

        // single request from client 0
        b_v0 = v0_cnt; b_v1 = v1_cnt; b_rd = rd_cnt;
        k = mcyc;
        set_req(0, 25'h000100, 11'd8, 1'b1); tick(1); clr_req(); tick(2);
        chk("single_rd_cycle", last_rd_cyc, k + 2);
        chk("single_rd_addr", last_rd_addr, 25'h000100);
        chk("single_rd_len", last_rd_len, 11'd8);
        mem_xfer(4);
        d = mcyc - 1;
        tick(1);
        chk("single_rd_count", rd_cnt - b_rd, 1);
        chk("single_c0_valids", v0_cnt - b_v0, 4);
        chk("single_c1_valids", v1_cnt - b_v1, 0);
        chk("single_done_cycle", last_d0, d);

        // simultaneous pair straight after reset: client 0 first
        do_reset();
        k = mcyc;
        set_req(0, 25'h0000A0, 11'd4, 1'b0);
        set_req(1, 25'h1000B0, 11'd6, 1'b1);
        tick(1); clr_req(); tick(2);
        chk("pair1_first_cycle", last_rd_cyc, k + 2);
        chk("pair1_first_addr", last_rd_addr, 25'h0000A0);
        mem_xfer(2);
        d = mcyc - 1;
        tick(2);
        chk("pair1_second_cycle", last_rd_cyc, d + 2);
        chk("pair1_second_addr", last_rd_addr, 25'h1000B0);
        b_v1 = v1_cnt;
        mem_xfer(3);
        chk("pair1_c1_valids", v1_cnt - b_v1, 3);
        // lone client 0 burst leaves priority with client 1
        set_req(0, 25'h0000C0, 11'd2, 1'b0); tick(1); clr_req(); tick(2);
        mem_xfer(1);
        set_req(0, 25'h0000D0, 11'd3, 1'b1);
        set_req(1, 25'h1000E0, 11'd5, 1'b0);
        tick(1); clr_req(); tick(2);
        chk("pair2_first_addr", last_rd_addr, 25'h1000E0);
        mem_xfer(2);
        tick(2);
        chk("pair2_second_addr", last_rd_addr, 25'h0000D0);
        mem_xfer(1);

        // overrun: client 1 requests twice while client 0 holds the grant
        chk("ovr_before", err_overrun, 1'b0);
        set_req(0, 25'h000200, 11'd4, 1'b0); tick(1); clr_req(); tick(2);
        set_req(1, 25'h1AAAAA, 11'd7, 1'b1); tick(1); clr_req(); tick(1);
        set_req(1, 25'h155555, 11'd9, 1'b0); tick(1); clr_req();
        chk("ovr_flag", err_overrun, 1'b1);
        mem_xfer(2);
        d = mcyc - 1;
        tick(2);
        chk("ovr_issue_cycle", last_rd_cyc, d + 2);
        chk("ovr_issue_addr", last_rd_addr, 25'h1AAAAA);
        chk("ovr_issue_len", last_rd_len, 11'd7);
        mem_xfer(1);

        // zero length with stray io_sdram strobes while not BUSY
        b_rd = rd_cnt; b_v0 = v0_cnt; b_d0 = d0_cnt;
        k = mcyc;
        set_req(0, 25'h000300, 11'd0, 1'b0); tick(1); clr_req();
        mem_burst_data_valid = 1'b1; mem_burst_data_done = 1'b1; tick(3);
        mem_burst_data_valid = 1'b0; mem_burst_data_done = 1'b0; tick(1);
        chk("zlen_done_cycle", last_d0, k + 3);
        chk("zlen_done_count", d0_cnt - b_d0, 1);
        chk("zlen_no_rd", rd_cnt - b_rd, 0);
        chk("zlen_no_valid", v0_cnt - b_v0, 0);

        // timeout with client 1 waiting
        chk("to_before", err_timeout, 1'b0);
        k = mcyc;
        set_req(0, 25'h000400, 11'd4, 1'b1); tick(1); clr_req();
        set_req(1, 25'h100500, 11'd5, 1'b0); tick(1); clr_req();
        tick(18);
        chk("to_done_cycle", last_d0, k + 2 + TO);
        chk("to_flag", err_timeout, 1'b1);
        chk("to_next_cycle", last_rd_cyc, k + 3 + TO);
        chk("to_next_addr", last_rd_addr, 25'h100500);
        mem_xfer(1);

        // reset in the middle of a client 0 burst
        set_req(0, 25'h000600, 11'd8, 1'b1); tick(1); clr_req(); tick(2);
        mem_burst_data_valid = 1'b1; tick(1); mem_burst_data_valid = 1'b0;
        b_v0 = v0_cnt; b_v1 = v1_cnt; b_d0 = d0_cnt; b_d1 = d1_cnt;
        reset_n = 1'b0; tick(2); reset_n = 1'b1;
        mem_xfer(3);
        tick(1);
        chk("rst_no_strobes", (v0_cnt - b_v0) + (v1_cnt - b_v1) + (d0_cnt - b_d0) + (d1_cnt - b_d1), 0);
        chk("rst_addr", mem_burst_addr, 25'h0);
        chk("rst_len", mem_burst_len, 11'h0);
        chk("rst_errs", {err_overrun, err_timeout}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
